// File: rtl/mua_frame_packer.sv
// mua_frame_packer: packs per-channel MUA samples into FIFO frames of
// {SYNC_WORD, frame number, NUM_CH data words}.
// Optional feature: define MUA_THR_FLAG_EN to set bit 23 of each data word
// when the sample is at or below its channel threshold (flag is 0 otherwise).
module mua_frame_packer #(
    parameter int          NUM_CH    = 160,
    parameter logic [31:0] SYNC_WORD = 32'hA5A5_5A5A
) (
    input  logic        bus_clk,
    input  logic        xike_reset,
    input  logic        mua_valid,
    output logic        mua_ready,
    input  logic [11:0] mua_ch,
    input  logic [31:0] mua_data,
    input  logic [31:0] thr_data,
    input  logic [31:0] mua_frame_No,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_din,
    output logic        frame_done,
    output logic [15:0] err_count
);

    localparam logic [11:0] LAST_CH = 12'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_hold_valid;
    logic [11:0] r_hold_ch;
    logic [31:0] r_hold_data;
    logic [31:0] r_hold_fno;
    logic [31:0] r_frame_no;
    logic [11:0] r_exp_ch;
    logic [15:0] r_err_count;
    logic [31:0] r_last_din;

    logic        w_accept;
    logic        w_drain;
    logic        w_start;
    logic        w_drop_err;
    logic        w_data_wr;
    logic        w_wr_en;
    logic        w_done;
    logic [31:0] w_word;
    logic [22:0] w_sat;
    logic        w_flag;
    logic [31:0] w_data_word;

`ifdef MUA_THR_FLAG_EN
    logic [31:0] r_hold_thr;

    // Threshold is captured alongside the sample it belongs to.
    always_ff @(posedge bus_clk) begin
        if (xike_reset) begin
            r_hold_thr <= '0;
        end else if (w_accept) begin
            r_hold_thr <= thr_data;
        end
    end

    assign w_flag = ($signed(r_hold_data) <= $signed(r_hold_thr));
`else
    // Flag disabled: thr_data is folded into a term forced low so the port
    // is referenced identically in both builds.
    assign w_flag = 1'b0 & (^thr_data);
`endif

    // Saturate the signed 32-bit sample to the signed 23-bit range.
    always_comb begin
        w_sat = r_hold_data[22:0];
        if ($signed(r_hold_data) > 32'sd4194303) begin
            w_sat = 23'h3F_FFFF;
        end else if ($signed(r_hold_data) < -32'sd4194304) begin
            w_sat = 23'h40_0000;
        end
    end

    assign w_data_word = {r_hold_ch[7:0], w_flag, w_sat};

    // Ready also covers the cycle in which the held sample is consumed, so the
    // holding register can refill back-to-back at one word per cycle.
    assign mua_ready  = !r_hold_valid || w_drain;
    assign w_accept   = mua_valid && mua_ready;

    assign fifo_wr_en = w_wr_en;
    assign fifo_din   = w_wr_en ? w_word : r_last_din;
    assign frame_done = w_done;
    assign err_count  = r_err_count;

    // State register.
    always_ff @(posedge bus_clk) begin
        if (xike_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_word       = '0;
        w_done       = 1'b0;
        w_drain      = 1'b0;
        w_start      = 1'b0;
        w_drop_err   = 1'b0;
        w_data_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_valid) begin
                    if (r_hold_ch == '0) begin
                        w_start      = 1'b1;
                        w_next_state = ST_HDR0;
                    end else begin
                        w_drain = 1'b1;
                    end
                end
            end
            ST_HDR0: begin
                if (!fifo_full) begin
                    w_wr_en      = 1'b1;
                    w_word       = SYNC_WORD;
                    w_next_state = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (!fifo_full) begin
                    w_wr_en      = 1'b1;
                    w_word       = r_frame_no;
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hold_valid) begin
                    if (r_hold_ch != r_exp_ch) begin
                        w_drain      = 1'b1;
                        w_drop_err   = 1'b1;
                        w_next_state = ST_IDLE;
                    end else if (!fifo_full) begin
                        w_wr_en   = 1'b1;
                        w_word    = w_data_word;
                        w_drain   = 1'b1;
                        w_data_wr = 1'b1;
                        if (r_exp_ch == LAST_CH) begin
                            w_done       = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Holding register, channel tracking, error counter and last FIFO word.
    always_ff @(posedge bus_clk) begin
        if (xike_reset) begin
            r_hold_valid <= 1'b0;
            r_hold_ch    <= '0;
            r_hold_data  <= '0;
            r_hold_fno   <= '0;
            r_frame_no   <= '0;
            r_exp_ch     <= '0;
            r_err_count  <= '0;
            r_last_din   <= '0;
        end else begin
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_ch    <= mua_ch;
                r_hold_data  <= mua_data;
                r_hold_fno   <= mua_frame_No;
            end else if (w_drain) begin
                r_hold_valid <= 1'b0;
            end

            if (w_start) begin
                r_frame_no <= r_hold_fno;
                r_exp_ch   <= '0;
            end else if (w_data_wr) begin
                r_exp_ch <= r_exp_ch + 12'd1;
            end

            if (w_drop_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 16'd1;
            end

            if (w_wr_en) begin
                r_last_din <= w_word;
            end
        end
    end

endmodule

// File: tb/tb_mua_frame_packer.sv
// Self-checking bench for mua_frame_packer (NUM_CH=4): directed vector table,
// hand-written corner sequences and a randomized run against a frame model.
module tb_mua_frame_packer;

    localparam int          NCH  = 4;
    localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

    logic        bus_clk = 1'b0;
    logic        xike_reset;
    logic        mua_valid;
    logic        mua_ready;
    logic [11:0] mua_ch;
    logic [31:0] mua_data;
    logic [31:0] thr_data;
    logic [31:0] mua_frame_No;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        frame_done;
    logic [15:0] err_count;

    mua_frame_packer #(.NUM_CH(NCH), .SYNC_WORD(SYNC)) u_dut (
        .bus_clk      (bus_clk),
        .xike_reset   (xike_reset),
        .mua_valid    (mua_valid),
        .mua_ready    (mua_ready),
        .mua_ch       (mua_ch),
        .mua_data     (mua_data),
        .thr_data     (thr_data),
        .mua_frame_No (mua_frame_No),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .frame_done   (frame_done),
        .err_count    (err_count)
    );

    always #5 bus_clk = ~bus_clk;

    int n_vec = 0;
    int n_err = 0;

    int unsigned cyc = 0;
    always @(posedge bus_clk) cyc <= cyc + 1;

    logic rst_seen = 1'b0;
    always @(posedge bus_clk) rst_seen <= xike_reset;

    typedef struct {
        logic [31:0] word;
        logic        done;
        int unsigned cyc;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        logic        done;
    } exp_t;

    wr_t  cap[$];
    exp_t exp_q[$];
    logic [31:0] mon_last = '0;
    int unsigned last_acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Write monitor, sampled mid-cycle after inputs settle.
    always @(negedge bus_clk) begin
        wr_t w;
        #2;
        if (rst_seen) mon_last = '0;
        if (fifo_wr_en) begin
            check("wr_while_full", {31'd0, fifo_full}, 32'd0);
            w.word = fifo_din;
            w.done = frame_done;
            w.cyc  = cyc;
            cap.push_back(w);
            mon_last = fifo_din;
        end else begin
            check("din_hold", fifo_din, mon_last);
            check("done_without_wr", {31'd0, frame_done}, 32'd0);
        end
    end

    // ---------------- reference model ----------------
    bit m_in  = 1'b0;
    int m_exp = 0;
    int m_err = 0;

    function automatic logic [31:0] mk_word(input logic [11:0] ch, input logic [31:0] d,
                                            input logic [31:0] t);
        longint      v;
        longint      s;
        logic [31:0] sv;
        logic        flag;
        v = longint'($signed(d));
        if (v > 4194303)       s = 4194303;
        else if (v < -4194304) s = -4194304;
        else                   s = v;
        sv = 32'(s);
`ifdef MUA_THR_FLAG_EN
        flag = ($signed(d) <= $signed(t));
`else
        flag = 1'b0 & t[0];
`endif
        return {ch[7:0], flag, sv[22:0]};
    endfunction

    task automatic model_feed(input logic [11:0] ch, input logic [31:0] d,
                              input logic [31:0] t, input logic [31:0] f);
        exp_t e;
        if (!m_in) begin
            if (ch != 12'd0) return;
            e.word = SYNC; e.done = 1'b0; exp_q.push_back(e);
            e.word = f;    e.done = 1'b0; exp_q.push_back(e);
            m_in  = 1'b1;
            m_exp = 0;
        end
        if (int'(ch) == m_exp) begin
            e.word = mk_word(ch, d, t);
            e.done = (m_exp == NCH - 1);
            exp_q.push_back(e);
            m_exp++;
            if (m_exp == NCH) m_in = 1'b0;
        end else begin
            m_in = 1'b0;
            if (m_err < 65535) m_err++;
        end
    endtask

    task automatic model_reset();
        m_in  = 1'b0;
        m_exp = 0;
        m_err = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [11:0] ch, input logic [31:0] d,
                        input logic [31:0] t, input logic [31:0] f);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge bus_clk);
            mua_valid    = 1'b1;
            mua_ch       = ch;
            mua_data     = d;
            thr_data     = t;
            mua_frame_No = f;
            #1;
            if (mua_ready) done = 1'b1;
            @(posedge bus_clk);
        end
        #1;
        mua_valid = 1'b0;
        if (done) begin
            last_acc_cyc = cyc;
            model_feed(ch, d, t, f);
        end else begin
            check("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic compare_stream(input string name);
        repeat (12) @(negedge bus_clk);
        #3;
        check({name, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), cap[i].word, exp_q[i].word);
            check($sformatf("%s_d%0d", name, i), {31'd0, cap[i].done}, {31'd0, exp_q[i].done});
        end
        check({name, "_err"}, {16'd0, err_count}, 32'(m_err));
        cap.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge bus_clk);
        xike_reset = 1'b1;
        mua_valid  = 1'b0;
        @(negedge bus_clk);
        xike_reset = 1'b0;
        model_reset();
        #3;
        cap.delete();
        exp_q.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [11:0] ch;
        logic [31:0] data;
        logic [31:0] thr;
        logic [31:0] fno;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl[8];

    task automatic run_table();
        exp_t        tq[$];
        exp_t        e;
        int unsigned acc0 = 0;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].ch, tbl[i].data, tbl[i].thr, tbl[i].fno);
            if (i == 0) acc0 = last_acc_cyc;
            if (tbl[i].ch == 12'd0) begin
                e.word = SYNC;        e.done = 1'b0; tq.push_back(e);
                e.word = tbl[i].fno;  e.done = 1'b0; tq.push_back(e);
            end
            e.word = tbl[i].exp_word;
            e.done = (tbl[i].ch == 12'(NCH - 1));
            tq.push_back(e);
        end
        repeat (12) @(negedge bus_clk);
        #3;
        check("tbl_len", 32'(cap.size()), 32'(tq.size()));
        for (int i = 0; i < cap.size() && i < tq.size(); i++) begin
            check($sformatf("tbl_w%0d", i), cap[i].word, tq[i].word);
            check($sformatf("tbl_d%0d", i), {31'd0, cap[i].done}, {31'd0, tq[i].done});
        end
        // First frame: header one cycle after ch0 accept, then one word per cycle.
        for (int j = 0; j < 6 && j < cap.size(); j++) begin
            check($sformatf("tbl_cyc%0d", j), 32'(cap[j].cyc), 32'(acc0 + 1 + j));
        end
        check("tbl_err", {16'd0, err_count}, 32'd0);
        cap.delete();
        exp_q.delete();
    endtask

    // ---------------- randomized run ----------------
    bit rand_on = 1'b0;

    task automatic run_random();
        int unsigned g_ch = 0;
        logic [11:0] ch;
        logic [31:0] d;
        logic [31:0] t;
        logic [31:0] fno = 32'h1000;
        int          bnd[4];
        bnd[0] = 4194303; bnd[1] = 4194304; bnd[2] = -4194304; bnd[3] = -4194305;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                ch   = 12'(g_ch);
                g_ch = (g_ch + 1) % NCH;
            end else begin
                ch = 12'($urandom_range(0, 5));
            end
            if (ch == 12'd0) fno = fno + 1;
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = 32'(int'($urandom_range(0, 16000000)) - 8000000);
                2: d = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
                default: d = 32'(bnd[$urandom_range(0, 3)]);
            endcase
            t = d + 32'(int'($urandom_range(0, 2)) - 1);
            send(ch, d, t, fno);
            if ($urandom_range(0, 9) == 0) @(negedge bus_clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        xike_reset   = 1'b1;
        mua_valid    = 1'b0;
        mua_ch       = '0;
        mua_data     = '0;
        thr_data     = '0;
        mua_frame_No = '0;
        fifo_full    = 1'b0;

        tbl[0] = '{12'd0, 32'd1, 32'd0, 32'h0000_1234, 32'h0000_0001};
        tbl[1] = '{12'd1, 32'd2, 32'd0, 32'h0000_1234, 32'h0100_0002};
        tbl[2] = '{12'd2, 32'd3, 32'd0, 32'h0000_1234, 32'h0200_0003};
        tbl[3] = '{12'd3, 32'd4, 32'd0, 32'h0000_1234, 32'h0300_0004};
        tbl[4] = '{12'd0, 32'h7FFF_FFFF, 32'd0, 32'h0000_1235, 32'h003F_FFFF};
`ifdef MUA_THR_FLAG_EN
        tbl[5] = '{12'd1, 32'h8000_0000, 32'd0, 32'h0000_1235, 32'h01C0_0000};
        tbl[6] = '{12'd2, -32'sd50, -32'sd40, 32'h0000_1235, 32'h02FF_FFCE};
`else
        tbl[5] = '{12'd1, 32'h8000_0000, 32'd0, 32'h0000_1235, 32'h0140_0000};
        tbl[6] = '{12'd2, -32'sd50, -32'sd40, 32'h0000_1235, 32'h027F_FFCE};
`endif
        tbl[7] = '{12'd3, 32'd10, -32'sd40, 32'h0000_1235, 32'h0300_000A};

        repeat (3) @(negedge bus_clk);
        xike_reset = 1'b0;
        #3;
        check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rst_din", fifo_din, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_ready", {31'd0, mua_ready}, 32'd1);
        check("rst_err", {16'd0, err_count}, 32'd0);

        // Basic frames, saturation and flag cases.
        run_table();

        // Backpressure for 5 cycles while the frame number is pending.
        send(12'd0, 32'd11, 32'd0, 32'h77);
        @(negedge bus_clk);
        @(negedge bus_clk);
        fork
            send(12'd1, 32'd12, 32'd0, 32'h77);
            begin
                @(negedge bus_clk);
                fifo_full = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check("ready_in_stall", {31'd0, mua_ready}, 32'd0);
                    @(negedge bus_clk);
                end
                fifo_full = 1'b0;
            end
        join
        send(12'd2, 32'd13, 32'd0, 32'h77);
        send(12'd3, 32'd14, 32'd0, 32'h77);
        compare_stream("stall");

        // Mid-frame channels with no header in progress are ignored silently.
        send(12'd2, 32'd5, 32'd0, 32'h80);
        send(12'd3, 32'd6, 32'd0, 32'h80);
        for (int c = 0; c < NCH; c++) send(12'(c), 32'(100 + c), 32'd0, 32'h81);
        compare_stream("resync");

        // Skipped channel drops the sample, counts an error and ends the frame.
        send(12'd0, 32'd7, 32'd0, 32'h90);
        send(12'd1, 32'd8, 32'd0, 32'h90);
        send(12'd3, 32'd9, 32'd0, 32'h90);
        compare_stream("skip");
        send(12'd1, 32'd9, 32'd0, 32'h90);
        compare_stream("skip_idle");

        // Reset after ch1 is written abandons the frame.
        send(12'd0, 32'd21, 32'd0, 32'hA0);
        send(12'd1, 32'd22, 32'd0, 32'hA0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge bus_clk);
                #3;
                if (cap.size() >= 4) seen = 1'b1;
            end
            if (!seen) check("rst_mid_wait", 32'd0, 32'd1);
        end
        check("pre_rst_err", {16'd0, err_count}, 32'd1);
        check("pre_rst_w3", cap[cap.size()-1].word, 32'h0100_0016);
        @(negedge bus_clk);
        xike_reset = 1'b1;
        @(negedge bus_clk);
        xike_reset = 1'b0;
        #3;
        check("post_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("post_rst_err", {16'd0, err_count}, 32'd0);
        check("post_rst_ready", {31'd0, mua_ready}, 32'd1);
        model_reset();
        cap.delete();
        exp_q.delete();
        for (int c = 0; c < NCH; c++) send(12'(c), 32'(200 + c), 32'd0, 32'hA1);
        compare_stream("after_rst");

        // Randomized samples with random FIFO backpressure.
        do_reset();
        rand_on = 1'b1;
        fork
            begin
                run_random();
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(negedge bus_clk);
                    fifo_full = ($urandom_range(0, 99) < 30);
                end
                fifo_full = 1'b0;
            end
        join
        fifo_full = 1'b0;
        compare_stream("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
